// File: rtl/alarm_pkg.sv
// Shared constants and FSM encoding for the multi-alarm controller.
package alarm_pkg;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RINGING = 2'd1,
        ST_SNOOZE  = 2'd2
    } alarm_state_t;

endpackage

// File: rtl/alarm_slot_bank.sv
// Alarm slot register file with lowest-index match encoder and a tone lookup
// that sees a same-cycle write, so the registered tone output never lags a write.
module alarm_slot_bank
    import alarm_pkg::*;
#(
    parameter int N_ALARMS = 4,
    parameter int TONE_W   = 2,
    parameter int IDX_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [HOUR_W-1:0] cfg_hour,
    input  logic [MIN_W-1:0]  cfg_min,
    input  logic              cfg_en,
    input  logic [TONE_W-1:0] cfg_tone,
    input  logic [HOUR_W-1:0] cur_hour,
    input  logic [MIN_W-1:0]  cur_min,
    input  logic [IDX_W-1:0]  sel_idx,
    output logic              match_any,
    output logic [IDX_W-1:0]  match_idx,
    output logic [TONE_W-1:0] sel_tone
);

    logic [N_ALARMS-1:0] slot_en;
    logic [HOUR_W-1:0]   slot_hour [N_ALARMS];
    logic [MIN_W-1:0]    slot_min  [N_ALARMS];
    logic [TONE_W-1:0]   slot_tone [N_ALARMS];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_en <= '0;
            for (int i = 0; i < N_ALARMS; i++) begin
                slot_hour[i] <= '0;
                slot_min[i]  <= '0;
                slot_tone[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_ALARMS; i++) begin
                if (cfg_we && (cfg_idx == IDX_W'(i))) begin
                    slot_en[i]   <= cfg_en;
                    slot_hour[i] <= cfg_hour;
                    slot_min[i]  <= cfg_min;
                    slot_tone[i] <= cfg_tone;
                end
            end
        end
    end

    // Scan high to low so the lowest matching index is the last assignment.
    always_comb begin
        match_any = 1'b0;
        match_idx = '0;
        for (int i = N_ALARMS - 1; i >= 0; i--) begin
            if (slot_en[i] && (slot_hour[i] == cur_hour) && (slot_min[i] == cur_min)) begin
                match_any = 1'b1;
                match_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        sel_tone = '0;
        for (int i = 0; i < N_ALARMS; i++) begin
            if (sel_idx == IDX_W'(i)) begin
                sel_tone = (cfg_we && (cfg_idx == sel_idx)) ? cfg_tone : slot_tone[i];
            end
        end
    end

endmodule

// File: rtl/multi_alarm_ctrl.sv
// Multi-slot alarm clock controller: trigger on minute match, ring timeout,
// bounded snooze, sticky missed flags. All outputs are registered.
module multi_alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int N_ALARMS   = 4,
    parameter int RING_SEC   = 60,
    parameter int SNOOZE_MIN = 9,
    parameter int MAX_SNOOZE = 3,
    parameter int TONE_W     = 2,
    parameter int IDX_W      = (N_ALARMS > 1) ? $clog2(N_ALARMS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                sec_tick,
    input  logic                min_tick,
    input  logic [HOUR_W-1:0]   cur_hour,
    input  logic [MIN_W-1:0]    cur_min,
    input  logic                cfg_we,
    input  logic [IDX_W-1:0]    cfg_idx,
    input  logic [HOUR_W-1:0]   cfg_hour,
    input  logic [MIN_W-1:0]    cfg_min,
    input  logic                cfg_en,
    input  logic [TONE_W-1:0]   cfg_tone,
    input  logic                snooze,
    input  logic                dismiss,
    input  logic                missed_clr,
    output logic                ring,
    output logic [IDX_W-1:0]    ring_idx,
    output logic [TONE_W-1:0]   ring_tone,
    output logic                snoozing,
    output logic [3:0]          snooze_left,
    output logic [N_ALARMS-1:0] missed
);

    localparam int SEC_W  = $clog2(RING_SEC + 1);
    localparam int MCNT_W = $clog2(SNOOZE_MIN + 1);

    alarm_state_t        state, state_nxt;
    logic [SEC_W-1:0]    sec_cnt, sec_cnt_nxt;
    logic [MCNT_W-1:0]   min_cnt, min_cnt_nxt;
    logic [IDX_W-1:0]    idx_nxt, match_idx;
    logic [TONE_W-1:0]   sel_tone, tone_nxt;
    logic [3:0]          snooze_left_nxt;
    logic [N_ALARMS-1:0] missed_nxt;
    logic                match_any, timeout, active_off, ring_nxt, snoozing_nxt;

    alarm_slot_bank #(
        .N_ALARMS (N_ALARMS),
        .TONE_W   (TONE_W),
        .IDX_W    (IDX_W)
    ) u_bank (
        .clk       (clk),
        .rst       (rst),
        .cfg_we    (cfg_we),
        .cfg_idx   (cfg_idx),
        .cfg_hour  (cfg_hour),
        .cfg_min   (cfg_min),
        .cfg_en    (cfg_en),
        .cfg_tone  (cfg_tone),
        .cur_hour  (cur_hour),
        .cur_min   (cur_min),
        .sel_idx   (idx_nxt),
        .match_any (match_any),
        .match_idx (match_idx),
        .sel_tone  (sel_tone)
    );

    // Disabling the slot currently ringing or snoozing aborts the episode.
    assign active_off = cfg_we && !cfg_en && (cfg_idx == ring_idx);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            sec_cnt <= '0;
            min_cnt <= '0;
        end else begin
            state   <= state_nxt;
            sec_cnt <= sec_cnt_nxt;
            min_cnt <= min_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt       = state;
        sec_cnt_nxt     = sec_cnt;
        min_cnt_nxt     = min_cnt;
        idx_nxt         = ring_idx;
        snooze_left_nxt = snooze_left;
        timeout         = 1'b0;
        case (state)
            ST_IDLE: begin
                if (min_tick && match_any) begin
                    state_nxt       = ST_RINGING;
                    idx_nxt         = match_idx;
                    snooze_left_nxt = 4'(MAX_SNOOZE);
                end
            end
            ST_RINGING: begin
                if (dismiss || active_off) begin
                    state_nxt = ST_IDLE;
                end else if (snooze) begin
                    if (snooze_left != 4'd0) begin
                        state_nxt       = ST_SNOOZE;
                        snooze_left_nxt = snooze_left - 4'd1;
                        min_cnt_nxt     = MCNT_W'(SNOOZE_MIN);
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (sec_tick) begin
                    if (sec_cnt == SEC_W'(RING_SEC - 1)) begin
                        state_nxt = ST_IDLE;
                        timeout   = 1'b1;
                    end else begin
                        sec_cnt_nxt = sec_cnt + 1'b1;
                    end
                end
            end
            ST_SNOOZE: begin
                if (dismiss || active_off) begin
                    state_nxt = ST_IDLE;
                end else if (min_tick) begin
                    if (min_cnt <= MCNT_W'(1)) begin
                        state_nxt   = ST_RINGING;
                        sec_cnt_nxt = '0;
                        min_cnt_nxt = '0;
                    end else begin
                        min_cnt_nxt = min_cnt - 1'b1;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (state_nxt == ST_IDLE) begin
            idx_nxt         = '0;
            snooze_left_nxt = '0;
            sec_cnt_nxt     = '0;
            min_cnt_nxt     = '0;
        end
    end

    always_comb begin
        ring_nxt     = (state_nxt == ST_RINGING);
        snoozing_nxt = (state_nxt == ST_SNOOZE);
        tone_nxt     = ring_nxt ? sel_tone : '0;
        missed_nxt   = missed & ~{N_ALARMS{missed_clr}};
        for (int i = 0; i < N_ALARMS; i++) begin
            if (timeout && (ring_idx == IDX_W'(i))) begin
                missed_nxt[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ring        <= 1'b0;
            ring_idx    <= '0;
            ring_tone   <= '0;
            snoozing    <= 1'b0;
            snooze_left <= '0;
            missed      <= '0;
        end else begin
            ring        <= ring_nxt;
            ring_idx    <= idx_nxt;
            ring_tone   <= tone_nxt;
            snoozing    <= snoozing_nxt;
            snooze_left <= snooze_left_nxt;
            missed      <= missed_nxt;
        end
    end

endmodule

// File: tb/tb_multi_alarm_ctrl.sv
// Directed bench for multi_alarm_ctrl with hand-computed expectations.
module tb_multi_alarm_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       sec_tick, min_tick;
    logic [4:0] cur_hour;
    logic [5:0] cur_min;
    logic       cfg_we;
    logic [1:0] cfg_idx;
    logic [4:0] cfg_hour;
    logic [5:0] cfg_min;
    logic       cfg_en;
    logic [1:0] cfg_tone;
    logic       snooze, dismiss, missed_clr;
    logic       ring;
    logic [1:0] ring_idx;
    logic [1:0] ring_tone;
    logic       snoozing;
    logic [3:0] snooze_left;
    logic [3:0] missed;

    int n_checks = 0;
    int n_errors = 0;

    multi_alarm_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .sec_tick    (sec_tick),
        .min_tick    (min_tick),
        .cur_hour    (cur_hour),
        .cur_min     (cur_min),
        .cfg_we      (cfg_we),
        .cfg_idx     (cfg_idx),
        .cfg_hour    (cfg_hour),
        .cfg_min     (cfg_min),
        .cfg_en      (cfg_en),
        .cfg_tone    (cfg_tone),
        .snooze      (snooze),
        .dismiss     (dismiss),
        .missed_clr  (missed_clr),
        .ring        (ring),
        .ring_idx    (ring_idx),
        .ring_tone   (ring_tone),
        .snoozing    (snoozing),
        .snooze_left (snooze_left),
        .missed      (missed)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_slot(input int idx, input int hh, input int mm, input bit en, input int tone);
        cfg_idx  = 2'(idx);
        cfg_hour = 5'(hh);
        cfg_min  = 6'(mm);
        cfg_en   = en;
        cfg_tone = 2'(tone);
        cfg_we   = 1'b1;
        tick();
        cfg_we   = 1'b0;
    endtask

    task automatic pulse_min(input int hh, input int mm);
        cur_hour = 5'(hh);
        cur_min  = 6'(mm);
        min_tick = 1'b1;
        tick();
        min_tick = 1'b0;
    endtask

    task automatic pulse_sec();
        sec_tick = 1'b1;
        tick();
        sec_tick = 1'b0;
    endtask

    task automatic pulse_snooze();
        snooze = 1'b1;
        tick();
        snooze = 1'b0;
    endtask

    task automatic pulse_dismiss();
        dismiss = 1'b1;
        tick();
        dismiss = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        {sec_tick, min_tick, cfg_we, cfg_en, snooze, dismiss, missed_clr} = '0;
        cur_hour = '0; cur_min = '0; cfg_idx = '0; cfg_hour = '0; cfg_min = '0; cfg_tone = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        check_eq("rst_ring", ring, 0);
        check_eq("rst_idx", ring_idx, 0);
        check_eq("rst_tone", ring_tone, 0);
        check_eq("rst_snoozing", snoozing, 0);
        check_eq("rst_left", snooze_left, 0);
        check_eq("rst_missed", missed, 0);

        // Single slot trigger
        cfg_slot(2, 7, 30, 1'b1, 3);
        pulse_min(7, 29);
        check_eq("no_match_ring", ring, 0);
        pulse_min(7, 30);
        check_eq("s2_ring", ring, 1);
        check_eq("s2_idx", ring_idx, 2);
        check_eq("s2_tone", ring_tone, 3);
        check_eq("s2_left", snooze_left, 3);
        pulse_dismiss();
        check_eq("dismiss_ring", ring, 0);
        check_eq("dismiss_snoozing", snoozing, 0);
        tick(); tick(); tick();
        check_eq("no_retrigger", ring, 0);

        // Two slots share a minute; lowest wins, then timeout
        cfg_slot(2, 7, 30, 1'b0, 3);
        cfg_slot(1, 6, 0, 1'b1, 1);
        cfg_slot(3, 6, 0, 1'b1, 2);
        pulse_min(6, 0);
        check_eq("dup_ring", ring, 1);
        check_eq("dup_idx", ring_idx, 1);
        check_eq("dup_tone", ring_tone, 1);
        for (int i = 0; i < 30; i++) pulse_sec();
        pulse_min(6, 0);
        check_eq("match_ignored_idx", ring_idx, 1);
        for (int i = 0; i < 29; i++) pulse_sec();
        check_eq("sec59_ring", ring, 1);
        pulse_sec();
        check_eq("timeout_ring", ring, 0);
        check_eq("timeout_missed", missed, 4'b0010);
        tick();
        check_eq("slot3_never", ring, 0);

        // Timeout coinciding with missed_clr: new flag survives, old one clears
        cfg_slot(0, 8, 0, 1'b1, 2);
        pulse_min(8, 0);
        check_eq("s0_idx", ring_idx, 0);
        check_eq("s0_tone", ring_tone, 2);
        for (int i = 0; i < 59; i++) pulse_sec();
        sec_tick = 1'b1; missed_clr = 1'b1;
        tick();
        sec_tick = 1'b0; missed_clr = 1'b0;
        check_eq("clr_vs_set", missed, 4'b0001);
        missed_clr = 1'b1;
        tick();
        missed_clr = 1'b0;
        check_eq("missed_clr", missed, 0);

        // Snooze chain until snooze budget is exhausted
        pulse_min(8, 0);
        check_eq("sz_ring", ring, 1);
        for (int i = 0; i < 30; i++) pulse_sec();
        pulse_snooze();
        check_eq("sz1_ring", ring, 0);
        check_eq("sz1_snoozing", snoozing, 1);
        check_eq("sz1_left", snooze_left, 2);
        check_eq("sz1_tone", ring_tone, 0);
        for (int i = 0; i < 8; i++) pulse_min(8, 1 + i);
        check_eq("sz1_still", snoozing, 1);
        pulse_min(8, 9);
        check_eq("sz1_back_ring", ring, 1);
        check_eq("sz1_back_left", snooze_left, 2);
        check_eq("sz1_back_idx", ring_idx, 0);
        check_eq("sz1_back_tone", ring_tone, 2);
        for (int i = 0; i < 59; i++) pulse_sec();
        check_eq("sec_cnt_cleared", ring, 1);
        for (int k = 0; k < 2; k++) begin
            pulse_snooze();
            check_eq("szk_snoozing", snoozing, 1);
            check_eq("szk_left", snooze_left, 1 - k);
            for (int i = 0; i < 9; i++) pulse_min(9, i);
            check_eq("szk_back_ring", ring, 1);
        end
        pulse_snooze();
        check_eq("sz4_ring", ring, 0);
        check_eq("sz4_snoozing", snoozing, 0);
        check_eq("sz4_left", snooze_left, 0);
        check_eq("sz4_missed", missed, 0);

        // Snooze and dismiss together
        pulse_min(8, 0);
        check_eq("both_pre_left", snooze_left, 3);
        snooze = 1'b1; dismiss = 1'b1;
        tick();
        snooze = 1'b0; dismiss = 1'b0;
        check_eq("both_ring", ring, 0);
        check_eq("both_snoozing", snoozing, 0);

        // Disabling the active slot aborts without a missed flag
        pulse_min(8, 0);
        check_eq("off_pre_ring", ring, 1);
        cfg_slot(0, 8, 0, 1'b0, 2);
        check_eq("off_ring", ring, 0);
        for (int i = 0; i < 60; i++) pulse_sec();
        check_eq("off_missed", missed, 0);

        // Asynchronous reset while ringing
        cfg_slot(2, 7, 30, 1'b1, 3);
        pulse_min(7, 30);
        check_eq("pre_rst_ring", ring, 1);
        rst = 1'b1;
        #1;
        check_eq("arst_ring", ring, 0);
        check_eq("arst_idx", ring_idx, 0);
        check_eq("arst_tone", ring_tone, 0);
        check_eq("arst_left", snooze_left, 0);
        tick();
        rst = 1'b0;
        tick();
        pulse_min(7, 30);
        check_eq("slots_cleared", ring, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
